// File: rtl/pix_pkg.sv
// Shared types and constants for the pixel frame capture block.
// Holds the FSM state encoding and the checksum / frame counter widths.
package pix_pkg;

  localparam int CSUM_W = 32;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/pix_frame_capture_if.sv
// Pixel stream bundle: frame-start strobe, beat valid and packed beat data.
// The source drives through master, the capture block listens through slave.
interface pix_frame_capture_if #(
  parameter int PPB = 2,
  parameter int CH  = 3,
  parameter int DW  = 8
);

  logic                  vsync;
  logic                  hsync;
  logic [PPB*CH*DW-1:0]  pix_data;

  modport master (output vsync, output hsync, output pix_data);
  modport slave  (input  vsync, input  hsync, input  pix_data);

endinterface

// File: rtl/pix_chan_accum.sv
// One colour channel: sums the PPB lanes of a beat and accumulates mod 2^32.
// clr together with en loads the beat sum, so a frame can start on its first beat.
module pix_chan_accum
  import pix_pkg::*;
#(
  parameter int PPB = 2,
  parameter int DW  = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              en,
  input  logic [PPB*DW-1:0] din,
  output logic [CSUM_W-1:0] acc
);

  logic [CSUM_W-1:0] lane [PPB];
  logic [CSUM_W-1:0] beat_sum;
  logic [CSUM_W-1:0] acc_reg;

  generate
    for (genvar gi = 0; gi < PPB; gi++) begin : g_lane
      assign lane[gi] = CSUM_W'(din[gi*DW +: DW]);
    end
  endgenerate

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < PPB; i++) begin
      beat_sum = beat_sum + lane[i];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= en ? beat_sum : '0;
    end else if (en) begin
      acc_reg <= acc_reg + beat_sum;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/pix_frame_capture.sv
// Frame capture: tracks column/row of incoming beats, per-channel checksums,
// frame completion and sticky protocol error flags.
module pix_frame_capture
  import pix_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int PPB    = 2,
  parameter int CH     = 3,
  parameter int DW     = 8,
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  pix_frame_capture_if.slave   pix,
  output logic [COL_W-1:0]     col,
  output logic [ROW_W-1:0]     row,
  output logic [CH*CSUM_W-1:0] csum,
  output logic                 frame_done,
  output logic                 Write_Done,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 err_short,
  output logic                 err_overrun
);

  state_t              state_reg;
  logic [COL_W-1:0]    col_reg;
  logic [ROW_W-1:0]    row_reg;
  logic                frame_done_reg;
  logic                write_done_reg;
  logic [FCNT_W-1:0]   frame_cnt_reg;
  logic                err_short_reg;
  logic                err_overrun_reg;

  logic                beat;
  logic                wrap;
  logic                last_beat;
  logic [COL_W-1:0]    cur_col;
  logic [ROW_W-1:0]    cur_row;
  logic [COL_W:0]      col_adv;

  // A vsync beat is positioned at the origin of the new frame, not the old one.
  assign beat      = pix.hsync && (pix.vsync || state_reg == CAPTURE);
  assign cur_col   = pix.vsync ? '0 : col_reg;
  assign cur_row   = pix.vsync ? '0 : row_reg;
  assign col_adv   = {1'b0, cur_col} + (COL_W+1)'(PPB);
  assign wrap      = (col_adv == (COL_W+1)'(WIDTH));
  assign last_beat = beat && wrap && (cur_row == ROW_W'(HEIGHT-1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg       <= IDLE;
      col_reg         <= '0;
      row_reg         <= '0;
      frame_done_reg  <= 1'b0;
      write_done_reg  <= 1'b0;
      frame_cnt_reg   <= '0;
      err_short_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (pix.vsync && state_reg == CAPTURE) begin
        err_short_reg <= 1'b1;
      end
      if (pix.hsync && !pix.vsync && state_reg != CAPTURE) begin
        err_overrun_reg <= 1'b1;
      end
      if (last_beat) begin
        state_reg      <= DONE;
        write_done_reg <= 1'b1;
        frame_done_reg <= 1'b1;
        frame_cnt_reg  <= frame_cnt_reg + FCNT_W'(1);
        col_reg        <= '0;
        row_reg        <= '0;
      end else if (pix.vsync || beat) begin
        state_reg      <= CAPTURE;
        write_done_reg <= 1'b0;
        if (!beat) begin
          col_reg <= '0;
          row_reg <= '0;
        end else if (wrap) begin
          col_reg <= '0;
          row_reg <= cur_row + ROW_W'(1);
        end else begin
          col_reg <= col_adv[COL_W-1:0];
          row_reg <= cur_row;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      logic [PPB*DW-1:0] chan_data;
      for (genvar gj = 0; gj < PPB; gj++) begin : g_pix
        assign chan_data[gj*DW +: DW] = pix.pix_data[(gj*CH+gi)*DW +: DW];
      end
      pix_chan_accum #(
        .PPB (PPB),
        .DW  (DW)
      ) u_accum (
        .clk  (HCLK),
        .srst (HRESET),
        .clr  (pix.vsync),
        .en   (beat),
        .din  (chan_data),
        .acc  (csum[gi*CSUM_W +: CSUM_W])
      );
    end
  endgenerate

  assign col         = col_reg;
  assign row         = row_reg;
  assign frame_done  = frame_done_reg;
  assign Write_Done  = write_done_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign err_short   = err_short_reg;
  assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_pix_frame_capture.sv
// Directed bench: 4x2 frame with PPB=2 for the main cases, plus a 1x1 PPB=1
// instance driven one frame per cycle to reach the frame counter wrap.
module tb_pix_frame_capture;
  import pix_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  pix_frame_capture_if #(.PPB(2), .CH(3), .DW(8)) pa ();
  pix_frame_capture_if #(.PPB(1), .CH(3), .DW(8)) pb ();

  logic [1:0]  a_col;
  logic [0:0]  a_row;
  logic [95:0] a_csum;
  logic        a_done, a_wd, a_es, a_eo;
  logic [15:0] a_cnt;

  logic [0:0]  b_col;
  logic [0:0]  b_row;
  logic [95:0] b_csum;
  logic        b_done, b_wd, b_es, b_eo;
  logic [15:0] b_cnt;

  pix_frame_capture #(.WIDTH(4), .HEIGHT(2), .PPB(2), .CH(3), .DW(8)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .pix(pa.slave),
    .col(a_col), .row(a_row), .csum(a_csum), .frame_done(a_done),
    .Write_Done(a_wd), .frame_cnt(a_cnt), .err_short(a_es), .err_overrun(a_eo)
  );

  pix_frame_capture #(.WIDTH(1), .HEIGHT(1), .PPB(1), .CH(3), .DW(8)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .pix(pb.slave),
    .col(b_col), .row(b_row), .csum(b_csum), .frame_done(b_done),
    .Write_Done(b_wd), .frame_cnt(b_cnt), .err_short(b_es), .err_overrun(b_eo)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] D01 = {6{8'h01}};
  localparam logic [47:0] DFF = {6{8'hFF}};
  localparam logic [47:0] D55 = {6{8'h55}};
  localparam logic [47:0] RGB = 48'h302010_302010;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep3(input logic [31:0] v);
    return {32'd0, v, v, v};
  endfunction

  task automatic step(input logic v, input logic h, input logic [47:0] d);
    pa.vsync = v;
    pa.hsync = h;
    pa.pix_data = d;
    @(posedge HCLK);
    #1;
    pa.vsync = 1'b0;
    pa.hsync = 1'b0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  initial begin
    pa.vsync = 1'b0; pa.hsync = 1'b0; pa.pix_data = '0;
    pb.vsync = 1'b0; pb.hsync = 1'b0; pb.pix_data = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_col",   128'(a_col),  128'(0));
    check("rst_row",   128'(a_row),  128'(0));
    check("rst_csum",  128'(a_csum), 128'(0));
    check("rst_done",  128'(a_done), 128'(0));
    check("rst_wd",    128'(a_wd),   128'(0));
    check("rst_cnt",   128'(a_cnt),  128'(0));
    check("rst_es",    128'(a_es),   128'(0));
    check("rst_eo",    128'(a_eo),   128'(0));
    HRESET = 1'b0;

    // Full frame of 8'h01 pixels
    step(1'b1, 1'b0, '0);
    check("a_vs_col",  128'(a_col), 128'(0));
    step(1'b0, 1'b1, D01);
    check("a_b1_csum", 128'(a_csum), rep3(32'd2));
    check("a_b1_col",  128'(a_col),  128'(2));
    step(1'b0, 1'b0, D01);
    check("a_stall_col",  128'(a_col),  128'(2));
    check("a_stall_csum", 128'(a_csum), rep3(32'd2));
    step(1'b0, 1'b1, D01);
    check("a_b2_col",  128'(a_col), 128'(0));
    check("a_b2_row",  128'(a_row), 128'(1));
    step(1'b0, 1'b1, D01);
    check("a_b3_done", 128'(a_done), 128'(0));
    step(1'b0, 1'b1, D01);
    check("a_done",    128'(a_done), 128'(1));
    check("a_wd",      128'(a_wd),   128'(1));
    check("a_cnt",     128'(a_cnt),  128'(1));
    check("a_csum",    128'(a_csum), rep3(32'd8));
    check("a_end_col", 128'(a_col),  128'(0));
    check("a_end_row", 128'(a_row),  128'(0));
    step(1'b0, 1'b0, '0);
    check("a_done_pulse", 128'(a_done), 128'(0));
    check("a_wd_hold",    128'(a_wd),   128'(1));
    step(1'b0, 1'b1, D55);
    check("a_done_ovr_eo",   128'(a_eo),   128'(1));
    check("a_done_ovr_csum", 128'(a_csum), rep3(32'd8));
    check("a_done_ovr_col",  128'(a_col),  128'(0));

    // Short frame restarted by vsync, then a full frame of 8'hFF
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, D01);
    step(1'b0, 1'b1, D01);
    step(1'b1, 1'b0, '0);
    check("b_es",   128'(a_es),   128'(1));
    check("b_csum0",128'(a_csum), 128'(0));
    check("b_col0", 128'(a_col),  128'(0));
    check("b_cnt0", 128'(a_cnt),  128'(0));
    repeat (4) step(1'b0, 1'b1, DFF);
    check("b_csum", 128'(a_csum), rep3(32'h7F8));
    check("b_cnt",  128'(a_cnt),  128'(1));
    check("b_es_sticky", 128'(a_es), 128'(1));
    check("b_wd",   128'(a_wd),   128'(1));

    // Beat in IDLE
    do_reset();
    step(1'b0, 1'b1, D55);
    check("c_eo",   128'(a_eo),   128'(1));
    check("c_csum", 128'(a_csum), 128'(0));
    check("c_col",  128'(a_col),  128'(0));
    check("c_wd",   128'(a_wd),   128'(0));

    // Reset during beat 3
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, D01);
    step(1'b0, 1'b1, D01);
    pa.hsync = 1'b1;
    pa.pix_data = D01;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    pa.hsync = 1'b0;
    check("d_col",  128'(a_col),  128'(0));
    check("d_row",  128'(a_row),  128'(0));
    check("d_csum", 128'(a_csum), 128'(0));
    check("d_cnt",  128'(a_cnt),  128'(0));
    check("d_wd",   128'(a_wd),   128'(0));
    check("d_done", 128'(a_done), 128'(0));
    check("d_eo",   128'(a_eo),   128'(0));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("d_done_later", 128'(a_done), 128'(0));

    // vsync and hsync together, from IDLE and again mid-frame
    do_reset();
    step(1'b1, 1'b1, RGB);
    check("e_csum", 128'(a_csum), {32'd0, 32'h60, 32'h40, 32'h20});
    check("e_col",  128'(a_col),  128'(2));
    check("e_row",  128'(a_row),  128'(0));
    check("e_es0",  128'(a_es),   128'(0));
    step(1'b1, 1'b1, RGB);
    check("e_es",    128'(a_es),   128'(1));
    check("e_csum2", 128'(a_csum), {32'd0, 32'h60, 32'h40, 32'h20});
    check("e_col2",  128'(a_col),  128'(2));
    repeat (3) step(1'b0, 1'b1, RGB);
    check("e_done",  128'(a_done), 128'(1));
    check("e_csum4", 128'(a_csum), {32'd0, 32'h180, 32'h100, 32'h80});
    check("e_cnt",   128'(a_cnt),  128'(1));

    // One-beat frames every cycle until the frame counter wraps
    do_reset();
    pb.vsync = 1'b1;
    pb.hsync = 1'b1;
    pb.pix_data = 24'h000001;
    repeat (65535) @(posedge HCLK);
    #1;
    check("f_cnt_max",  128'(b_cnt),  128'(16'hFFFF));
    check("f_done_max", 128'(b_done), 128'(1));
    @(posedge HCLK);
    #1;
    check("f_cnt_wrap",  128'(b_cnt),  128'(0));
    check("f_done_wrap", 128'(b_done), 128'(1));
    pb.vsync = 1'b0;
    pb.hsync = 1'b0;
    @(posedge HCLK);
    #1;
    check("f_done_off", 128'(b_done), 128'(0));
    check("f_wd",       128'(b_wd),   128'(1));
    check("f_csum",     128'(b_csum), rep3(32'd0) | 128'(32'd1));
    check("f_es",       128'(b_es),   128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
